switch_debouncer: RTL and testbench

- Input conditioning stage between the board slide switches and the combinational gate logic (the 3-input NAND lab gate). Its sw_o outputs drive that gate's a, b and c inputs directly.
- Synchronises each raw asynchronous switch into the clock domain, then rejects mechanical bounce.
- Outputs a clean level per channel, plus one-cycle rise and fall pulses for later counter/FSM labs.
- Channels are fully independent.

---
 rtl/switch_pkg.sv | 15 +
 rtl/debounce_channel.sv | 116 +++++++++++
 rtl/switch_debouncer.sv | 34 +++
 tb/tb_switch_debouncer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared types and board constants for the slide-switch conditioning stage.
package switch_pkg;

  typedef enum logic [1:0] {
    S_LO,
    S_WAIT_HI,
    S_HI,
    S_WAIT_LO
  } deb_state_t;

  // 10 ms of qualification at the 50 MHz board clock.
  localparam int DEFAULT_STABLE_CYCLES = 500000;
  localparam int CLK_HZ                = 50_000_000;

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: 2-flop synchroniser, qualification FSM with saturating
// counter, and registered level / rise / fall outputs.
module debounce_channel
  import switch_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             meta_q, sync_q;
  deb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Plain two-flop chain: nothing may sit between meta_q and sync_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= raw_i;
      sync_q <= meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Any reversal while waiting drops back to the stable state with cnt=0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      S_LO: begin
        if (sync_q) begin
          state_d = S_WAIT_HI;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      S_WAIT_HI: begin
        if (!sync_q) begin
          state_d = S_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_HI;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_HI: begin
        if (!sync_q) begin
          state_d = S_WAIT_LO;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      S_WAIT_LO: begin
        if (sync_q) begin
          state_d = S_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_LO;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_LO;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces N_CH independent slide switches feeding the NAND lab gate and
// provides per-channel rise/fall pulses.
module switch_debouncer
  import switch_pkg::*;
#(
  parameter int N_CH          = 3,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] sw_i,
  output logic [N_CH-1:0] sw_o,
  output logic [N_CH-1:0] rise_o,
  output logic [N_CH-1:0] fall_o
);

  if (STABLE_CYCLES < 1) begin : g_param_check
    $error("switch_debouncer: STABLE_CYCLES must be >= 1");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_i  (sw_i[i]),
      .level_o(sw_o[i]),
      .rise_o (rise_o[i]),
      .fall_o (fall_o[i])
    );
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: directed latency/bounce/reset cases plus random
// switch activity compared against a sliding-window reference model.
module tb_switch_debouncer;

  localparam int N_CH   = 3;
  localparam int STABLE = 4;
  localparam int LAT    = STABLE + 3;

  logic            clk;
  logic            rst_n;
  logic [N_CH-1:0] sw_i;
  logic [N_CH-1:0] sw_o;
  logic [N_CH-1:0] rise_o;
  logic [N_CH-1:0] fall_o;

  int checks = 0;
  int errors = 0;

  // Reference model: a new level is accepted once the FSM-visible input
  // (sw_i two edges late) has disagreed with the level for STABLE+1 edges.
  logic [N_CH-1:0] hist[$];
  logic [N_CH-1:0] lvl_m, rise_m, fall_m;

  switch_debouncer #(
    .N_CH         (N_CH),
    .STABLE_CYCLES(STABLE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw_i  (sw_i),
    .sw_o  (sw_o),
    .rise_o(rise_o),
    .fall_o(fall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < STABLE + 2; i++) hist.push_back('0);
    lvl_m  = '0;
    rise_m = '0;
    fall_m = '0;
  endtask

  task automatic model_edge(input logic [N_CH-1:0] s);
    logic flip;
    if (hist.size() >= STABLE + 3) void'(hist.pop_front());
    hist.push_back(s);
    rise_m = '0;
    fall_m = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      flip = 1'b1;
      for (int j = 0; j <= STABLE; j++)
        if (hist[hist.size() - 3 - j][ch] == lvl_m[ch]) flip = 1'b0;
      if (flip) begin
        lvl_m[ch] = ~lvl_m[ch];
        if (lvl_m[ch]) rise_m[ch] = 1'b1;
        else           fall_m[ch] = 1'b1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge(sw_i);
    @(negedge clk);
    check_val("sw_o", 32'(sw_o), 32'(lvl_m));
    check_val("rise_o", 32'(rise_o), 32'(rise_m));
    check_val("fall_o", 32'(fall_o), 32'(fall_m));
    check_val("rise_and_fall", 32'(rise_o & fall_o), 32'd0);
  endtask

  task automatic run_edge(input string tag, input logic [N_CH-1:0] mask, input logic rising);
    logic [N_CH-1:0] pre, post;
    pre  = rising ? '0 : mask;
    post = rising ? mask : '0;
    for (int e = 1; e <= LAT; e++) begin
      step();
      if (e < LAT) begin
        check_val({tag, "_hold"}, 32'(sw_o & mask), 32'(pre));
      end else begin
        check_val({tag, "_commit"}, 32'(sw_o & mask), 32'(post));
        check_val({tag, "_pulse"}, 32'(rising ? rise_o : fall_o), 32'(mask));
      end
    end
    step();
    check_val({tag, "_one_cycle"}, 32'(rise_o | fall_o), 32'd0);
  endtask

  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_val({tag, "_async_clear"}, 32'({sw_o, rise_o, fall_o}), 32'd0);
    model_reset();
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    sw_i  = '0;
    model_reset();
    step();
    step();
    check_val("reset_state", 32'({sw_o, rise_o, fall_o}), 32'd0);
    rst_n = 1'b1;

    // Idle
    for (int i = 0; i < 20; i++) step();
    check_val("idle_sw_o", 32'(sw_o), 32'd0);

    // Single clean rising edge on channel 0
    sw_i = 3'b001;
    run_edge("ch0_rise", 3'b001, 1'b1);
    check_val("ch0_others", 32'(sw_o), 32'b001);

    // Bounce on channel 1 then hold high
    sw_i[1] = 1'b1; step();
    sw_i[1] = 1'b0; step();
    sw_i[1] = 1'b1; step();
    sw_i[1] = 1'b0; step();
    check_val("ch1_bounce_lvl", 32'(sw_o[1]), 32'd0);
    sw_i[1] = 1'b1;
    run_edge("ch1_bounce", 3'b010, 1'b1);

    // Return to all-low, then simultaneous rise and fall on every channel
    sw_i = 3'b000;
    for (int i = 0; i < LAT + 2; i++) step();
    check_val("all_low", 32'(sw_o), 32'd0);
    sw_i = 3'b111;
    run_edge("all_rise", 3'b111, 1'b1);
    sw_i = 3'b000;
    run_edge("all_fall", 3'b111, 1'b0);

    // Short pulse on channel 2 is rejected
    sw_i[2] = 1'b1;
    for (int i = 0; i < 3; i++) step();
    sw_i[2] = 1'b0;
    for (int i = 0; i < LAT + 3; i++) begin
      step();
      check_val("ch2_glitch", 32'({sw_o[2], rise_o[2], fall_o[2]}), 32'd0);
    end

    // Reset in the middle of qualification, switches held through it
    sw_i = 3'b110;
    run_edge("pre_rst", 3'b110, 1'b1);
    sw_i = 3'b111;
    for (int i = 0; i < 4; i++) step();
    async_reset("midqual");
    run_edge("rst_requal", 3'b111, 1'b1);

    // Random switch activity with both bounce and long holds
    for (int i = 0; i < 800; i++) begin
      if (i == 400) async_reset("random");
      if (i % 200 < 100) begin
        if ($urandom_range(0, 1) == 0) sw_i = sw_i ^ N_CH'($urandom);
      end else begin
        if ($urandom_range(0, 11) == 0) sw_i = sw_i ^ N_CH'($urandom);
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
